// File: rtl/video_pkg.sv
// Shared timing defaults, pattern encoding and colour-bar table for the video timing generator.
package video_pkg;

    localparam int unsigned CNT_W = 13;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_SQ_SIZE  = 32;

    localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef enum logic [1:0] {
        PatBlack      = 2'd0,
        PatBars       = 2'd1,
        PatSquare     = 2'd2,
        PatBarsSquare = 2'd3
    } pattern_e;

    // {R,G,B} on/off per bar, index 0 is the leftmost bar:
    // white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [7:0][2:0] BAR_TABLE = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

    // One axis of the bouncing square: position plus direction (neg = moving towards 0)
    typedef struct packed {
        logic             neg;
        logic [CNT_W-1:0] pos;
    } axis_t;

    // Advance one axis by one pixel, reversing first if the step would leave [0, lim]
    function automatic axis_t step_axis(axis_t cur, logic [CNT_W-1:0] lim);
        axis_t nxt;
        nxt = cur;
        if (!cur.neg && cur.pos == lim) begin
            nxt.neg = 1'b1;
        end else if (cur.neg && cur.pos == '0) begin
            nxt.neg = 1'b0;
        end
        nxt.pos = nxt.neg ? cur.pos - CNT_W'(1) : cur.pos + CNT_W'(1);
        return nxt;
    endfunction

endpackage

// File: rtl/video_counter.sv
// Horizontal/vertical raster counter pair, advancing on pixel-clock enable.
module video_counter
    import video_pkg::*;
#(
    parameter int unsigned H_TOT = H_TOTAL,
    parameter int unsigned V_TOT = V_TOTAL
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             pix_en,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);

    // Pixel counter wraps each line; line counter steps on that wrap and wraps each frame
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pix_en) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + CNT_W'(1);
            end else begin
                hcnt <= hcnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// VGA-style timing generator with colour bars and a bouncing square test pattern.
// All outputs are registered from the same counter value, one cycle behind the counters.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int unsigned PIXEL_DEPTH = 8,
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned H_FP        = DEF_H_FP,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BP        = DEF_H_BP,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned V_FP        = DEF_V_FP,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BP        = DEF_V_BP,
    parameter int unsigned SQ_SIZE     = DEF_SQ_SIZE
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   pix_en,
    input  logic [1:0]             pattern_sel,
    output logic                   vs_no,
    output logic                   hs_no,
    output logic                   blank_no,
    output logic                   en_o,
    output logic                   color_o,
    output logic [CNT_W-1:0]       row,
    output logic [CNT_W-1:0]       col,
    output logic [PIXEL_DEPTH-1:0] output_R,
    output logic [PIXEL_DEPTH-1:0] output_G,
    output logic [PIXEL_DEPTH-1:0] output_B,
    output logic                   frame_o
);

    localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] HA       = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] VA       = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] SQ       = CNT_W'(SQ_SIZE);
    localparam logic [CNT_W-1:0] X_MAX    = CNT_W'(H_ACTIVE - SQ_SIZE);
    localparam logic [CNT_W-1:0] Y_MAX    = CNT_W'(V_ACTIVE - SQ_SIZE);
    localparam logic [CNT_W-1:0] X_INIT   = CNT_W'((H_ACTIVE - SQ_SIZE) / 2);
    localparam logic [CNT_W-1:0] Y_INIT   = CNT_W'((V_ACTIVE - SQ_SIZE) / 2);
    localparam logic [CNT_W-1:0] BAR_W    = CNT_W'(H_ACTIVE / 8);

    logic [CNT_W-1:0] hcnt, vcnt;
    axis_t            sq_x, sq_y;
    pattern_e         pat_q;

    logic       active, hs_act, vs_act, in_sq, frame_start, frame_bound, sq_hit;
    logic [2:0] bar_idx, pix_rgb;

    video_counter #(
        .H_TOT (H_TOT),
        .V_TOT (V_TOT)
    ) u_counter (
        .clk    (clk),
        .rstn   (rstn),
        .pix_en (pix_en),
        .hcnt   (hcnt),
        .vcnt   (vcnt)
    );

    // Decode timing regions and the selected pattern from the current counter value
    always_comb begin
        active      = (hcnt < HA) && (vcnt < VA);
        hs_act      = (hcnt >= HS_START) && (hcnt < HS_END);
        vs_act      = (vcnt >= VS_START) && (vcnt < VS_END);
        in_sq       = (hcnt >= sq_x.pos) && (hcnt < sq_x.pos + SQ) &&
                      (vcnt >= sq_y.pos) && (vcnt < sq_y.pos + SQ);
        frame_start = (hcnt == '0) && (vcnt == '0);
        // First line of vertical blanking: safe point to move the square and switch pattern
        frame_bound = (hcnt == '0) && (vcnt == VA);
        bar_idx     = 3'(hcnt / BAR_W);
        pix_rgb     = 3'b000;
        sq_hit      = 1'b0;
        case (pat_q)
            PatBlack: begin
                pix_rgb = 3'b000;
            end
            PatBars: begin
                pix_rgb = BAR_TABLE[bar_idx];
            end
            PatSquare: begin
                sq_hit  = in_sq;
                pix_rgb = in_sq ? 3'b111 : 3'b000;
            end
            PatBarsSquare: begin
                sq_hit  = in_sq;
                pix_rgb = in_sq ? 3'b111 : BAR_TABLE[bar_idx];
            end
            default: begin
                pix_rgb = 3'b000;
            end
        endcase
    end

    // Once per frame: bounce the square one step and latch the requested pattern
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sq_x  <= '{neg: 1'b0, pos: X_INIT};
            sq_y  <= '{neg: 1'b0, pos: Y_INIT};
            pat_q <= PatBlack;
        end else if (pix_en && frame_bound) begin
            sq_x  <= step_axis(sq_x, X_MAX);
            sq_y  <= step_axis(sq_y, Y_MAX);
            pat_q <= pattern_e'(pattern_sel);
        end
    end

    // Registered outputs; en_o tracks pix_en every cycle, everything else holds without it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            en_o     <= 1'b0;
            row      <= '0;
            col      <= '0;
            vs_no    <= 1'b1;
            hs_no    <= 1'b1;
            blank_no <= 1'b0;
            color_o  <= 1'b0;
            frame_o  <= 1'b0;
            output_R <= '0;
            output_G <= '0;
            output_B <= '0;
        end else begin
            en_o <= pix_en;
            if (pix_en) begin
                row      <= vcnt;
                col      <= hcnt;
                vs_no    <= ~vs_act;
                hs_no    <= ~hs_act;
                blank_no <= active;
                color_o  <= active & sq_hit;
                frame_o  <= frame_start;
                output_R <= {PIXEL_DEPTH{pix_rgb[2] & active}};
                output_G <= {PIXEL_DEPTH{pix_rgb[1] & active}};
                output_B <= {PIXEL_DEPTH{pix_rgb[0] & active}};
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen using a shrunken raster so many frames fit in the run.
module tb_video_timing_gen;

    localparam int HA = 32, HFP = 2, HSY = 4, HBP = 2;
    localparam int VA = 24, VFP = 2, VSY = 2, VBP = 2;
    localparam int SQ = 8;
    localparam int HT = HA + HFP + HSY + HBP;  // 40
    localparam int VT = VA + VFP + VSY + VBP;  // 30
    localparam int X0 = (HA - SQ) / 2;         // 12
    localparam int Y0 = (VA - SQ) / 2;         // 8

    typedef struct packed {
        logic        vs, hs, blank, en, color, frame;
        logic [12:0] row, col;
        logic [7:0]  r, g, b;
    } out_t;

    localparam out_t RST = '{vs: 1'b1, hs: 1'b1, default: '0};

    typedef struct packed {
        int   f, r, c;
        logic e;
    } pt_t;

    // Expected color_o at (frame, row, col) once pattern 2 is live; square moves +1,+1 per frame
    pt_t pts [11] = '{
        '{2, 10, 14, 1'b1}, '{2, 17, 21, 1'b1}, '{2, 10, 22, 1'b0}, '{2, 9, 14, 1'b0},
        '{3, 11, 15, 1'b1}, '{3, 10, 14, 1'b0},
        '{12, 12, 24, 1'b1}, '{12, 19, 31, 1'b1},
        '{13, 11, 23, 1'b1}, '{13, 11, 31, 1'b0}, '{13, 11, 22, 1'b0}
    };

    logic        clk, rstn, pix_en;
    logic [1:0]  pattern_sel;
    logic        vs_no, hs_no, blank_no, en_o, color_o, frame_o;
    logic [12:0] row, col;
    logic [7:0]  out_r, out_g, out_b;
    out_t        act;

    int n_checks = 0;
    int n_fail   = 0;

    video_timing_gen #(
        .PIXEL_DEPTH (8),
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP),
        .SQ_SIZE  (SQ)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .pix_en      (pix_en),
        .pattern_sel (pattern_sel),
        .vs_no       (vs_no),
        .hs_no       (hs_no),
        .blank_no    (blank_no),
        .en_o        (en_o),
        .color_o     (color_o),
        .row         (row),
        .col         (col),
        .output_R    (out_r),
        .output_G    (out_g),
        .output_B    (out_b),
        .frame_o     (frame_o)
    );

    assign act = {vs_no, hs_no, blank_no, en_o, color_o, frame_o, row, col, out_r, out_g, out_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
        end
    endtask

    // Position of a square bouncing inside [0, m] after k one-pixel steps from 0
    function automatic int bounce_pos(int k, int m);
        int r;
        if (m == 0) return 0;
        r = k % (2 * m);
        return (r <= m) ? r : 2 * m - r;
    endfunction

    // Reference pixel: n = number of frame-boundary square moves so far, p = latched pattern
    function automatic out_t model_px(int hc, int vc, int n, logic [1:0] p);
        out_t       e;
        int         x, y, bar;
        logic       vis, insq;
        logic [2:0] on;
        e       = '0;
        vis     = (hc < HA) && (vc < VA);
        x       = bounce_pos(X0 + n, HA - SQ);
        y       = bounce_pos(Y0 + n, VA - SQ);
        insq    = (hc >= x) && (hc < x + SQ) && (vc >= y) && (vc < y + SQ);
        bar     = hc / (HA / 8);
        // white,yellow,cyan,green,magenta,red,blue,black: R off in bars 2,3,6,7; G off 4..7; B odd
        on      = {((bar / 2) % 2) == 0, bar < 4, (bar % 2) == 0};
        if (p == 2'd0) on = 3'b000;
        if (p == 2'd2) on = insq ? 3'b111 : 3'b000;
        if (p == 2'd3 && insq) on = 3'b111;
        if (!vis) on = 3'b000;
        e.vs    = !((vc >= VA + VFP) && (vc < VA + VFP + VSY));
        e.hs    = !((hc >= HA + HFP) && (hc < HA + HFP + HSY));
        e.blank = vis;
        e.color = vis && insq && p[1];
        e.frame = (hc == 0) && (vc == 0);
        e.row   = 13'(vc);
        e.col   = 13'(hc);
        e.r     = on[2] ? 8'hFF : 8'h00;
        e.g     = on[1] ? 8'hFF : 8'h00;
        e.b     = on[0] ? 8'hFF : 8'h00;
        return e;
    endfunction

    // Reference model: predicts the output word after each rising edge and queues it
    out_t       expq [$];
    out_t       last_e = RST;
    out_t       e_cur;
    int         m_pos = 0, m_moves = 0;
    logic [1:0] m_pat = 2'd0;

    always @(posedge clk) begin
        if (!rstn) begin
            m_pos   = 0;
            m_moves = 0;
            m_pat   = 2'd0;
            e_cur   = RST;
        end else if (pix_en) begin
            e_cur    = model_px(m_pos % HT, m_pos / HT, m_moves, m_pat);
            e_cur.en = 1'b1;
            if (m_pos == VA * HT) begin
                m_moves = m_moves + 1;
                m_pat   = pattern_sel;
            end
            m_pos = (m_pos + 1) % (HT * VT);
        end else begin
            e_cur    = last_e;
            e_cur.en = 1'b0;
        end
        last_e = e_cur;
        expq.push_back(e_cur);
    end

    // Monitor: pops one prediction per cycle, plus directed checks during the first run
    out_t exp_m;
    int   cyc = 0, fidx = -1, stamp0 = 0, hs_low = 0, vs_low = 0;
    bit   first_run = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (expq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_queue at %0t: got empty queue, expected a prediction", $time);
        end else begin
            exp_m = expq.pop_front();
            check("scoreboard", 64'(act), 64'(exp_m));
        end
        if (!rstn) begin
            fidx   = -1;
            hs_low = 0;
            vs_low = 0;
        end else if (en_o && first_run) begin
            if (frame_o) begin
                fidx++;
                if (fidx == 0) stamp0 = cyc;
                if (fidx == 1) check("frame_period", 64'(cyc - stamp0), 64'(HT * VT));
                if (fidx == 2) begin
                    check("hs_low_2frames", 64'(hs_low), 64'(HSY * VT * 2));
                    check("vs_low_2frames", 64'(vs_low), 64'(VSY * HT * 2));
                end
            end
            if (fidx >= 0 && fidx <= 1) begin
                if (!hs_no) hs_low++;
                if (!vs_no) vs_low++;
            end
            if (fidx == 1 && row == 13'd10) begin
                case (col)
                    13'd0, 13'd3: check("bar_white", {out_r, out_g, out_b}, 24'hFFFFFF);
                    13'd4:        check("bar_yellow", {out_r, out_g, out_b}, 24'hFFFF00);
                    13'd28, 13'd31: check("bar_black", {out_r, out_g, out_b}, 24'h000000);
                    13'd32:       check("bar_blank", {blank_no, out_r, out_g, out_b}, 25'h0);
                    default: ;
                endcase
            end
            foreach (pts[i]) begin
                if (fidx == pts[i].f && int'(row) == pts[i].r && int'(col) == pts[i].c)
                    check($sformatf("square_f%0d_r%0d_c%0d", pts[i].f, pts[i].r, pts[i].c),
                          64'(color_o), 64'(pts[i].e));
            end
        end
    end

    initial begin
        rstn        = 1'b0;
        pix_en      = 1'b0;
        pattern_sel = 2'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #3;
        rstn   = 1'b1;
        pix_en = 1'b1;
        // Two full frames with pix_en high; switch to the square mid-frame 1
        repeat (1800) @(posedge clk);
        #1;
        pattern_sel = 2'd2;
        repeat (600) @(posedge clk);
        #1;
        for (int i = 0; i < 30000 && fidx < 14; i++) begin
            pix_en = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        check("reach_frame14", 64'(fidx >= 14), 64'd1);
        for (int i = 0; i < 3000 && !(en_o && row == 13'd20); i++) begin
            pix_en = ($urandom_range(0, 1) != 0);
            @(posedge clk);
            #1;
        end
        check("reach_row20", 64'(row), 64'd20);
        // Mid-frame reset: outputs must drop to reset values without waiting for a clock
        @(negedge clk);
        #3;
        rstn      = 1'b0;
        first_run = 1'b0;
        #1;
        check("async_reset", 64'(act), 64'(RST));
        repeat (2) @(posedge clk);
        @(negedge clk);
        #3;
        rstn   = 1'b1;
        pix_en = ($urandom_range(0, 1) != 0);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (en_o) break;
            pix_en = ($urandom_range(0, 1) != 0);
        end
        check("restart_rowcol", {en_o, frame_o, row, col}, {1'b1, 1'b1, 26'd0});
        repeat (1300) begin
            pix_en = ($urandom_range(0, 1) != 0);
            @(posedge clk);
            #1;
        end
        pix_en = 1'b0;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 The block SHALL have parameter PIXEL_DEPTH, default 8, giving the bits per colour channel.
REQ-002 The block SHALL have parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48, giving the horizontal timing in pixels.
REQ-003 The block SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, giving the vertical timing in lines.
REQ-004 The block SHALL have parameter SQ_SIZE, default 32, giving the moving-square edge length in pixels.
REQ-005 The block SHALL have these ports, one per line:
- clk  in  1  clock; one clock domain only.
- rstn  in  1  asynchronous, active-low reset.
- pix_en  in  1  pixel-clock enable; counters advance only when high.
- pattern_sel  in  2  pattern select: 0 black, 1 colour bars, 2 moving square, 3 bars with square overlaid.
- vs_no  out  1  vertical sync, active low.
- hs_no  out  1  horizontal sync, active low.
- blank_no  out  1  low outside the active area.
- en_o  out  1  pix_en delayed one cycle, aligned with the other outputs.
- color_o  out  1  high when the pixel lies inside the square.
- row  out  13  line index, 0 to V_TOTAL-1.
- col  out  13  pixel index, 0 to H_TOTAL-1.
- output_R/G/B  out  PIXEL_DEPTH each  pixel colour.
- frame_o  out  1  one-cycle pulse at row 0, col 0.

Function
REQ-006 H_TOTAL SHALL equal the sum of the H parameters (800) and V_TOTAL the sum of the V parameters (525).
REQ-007 When pix_en is high, hcnt SHALL increment and wrap from H_TOTAL-1 to 0; on that wrap vcnt SHALL increment and wrap from V_TOTAL-1 to 0.
REQ-008 When pix_en is low, all counters and registered outputs SHALL hold, except en_o.
REQ-009 All outputs SHALL be registered: on each pix_en cycle, row/col SHALL load the current vcnt/hcnt and every decode SHALL be computed from that same counter value, so all outputs stay mutually aligned with one cycle of latency.
REQ-010 blank_no SHALL be high iff col < H_ACTIVE and row < V_ACTIVE.
REQ-011 hs_no SHALL be low iff H_ACTIVE+H_FP <= col < H_ACTIVE+H_FP+H_SYNC (656..751).
REQ-012 vs_no SHALL be low iff V_ACTIVE+V_FP <= row < V_ACTIVE+V_FP+V_SYNC (490..491), over full lines.
REQ-013 RGB SHALL be 0 whenever blank_no is low, regardless of pattern.
REQ-014 Colour bars SHALL be 8 bars of H_ACTIVE/8 px each, left to right: white, yellow, cyan, green, magenta, red, blue, black. Each channel is all-ones or zero.
REQ-015 The square SHALL occupy sq_x <= col < sq_x+SQ_SIZE and sq_y <= row < sq_y+SQ_SIZE; it is drawn white in modes 2 and 3, on a black background in mode 2.
REQ-016 color_o SHALL be asserted inside the square in modes 2 and 3 only, and SHALL be 0 while blanking.
REQ-017 The square position SHALL update once per frame, on the pix_en cycle where vcnt=V_ACTIVE and hcnt=0, by adding dx and dy (each ±1).
REQ-018 A velocity component SHALL be negated before the add if the step would leave the active area: sq_x+SQ_SIZE = H_ACTIVE with dx=+1, or sq_x = 0 with dx=-1; the same rule applies to y. The square SHALL never leave the active area.
REQ-019 pattern_sel SHALL be sampled into an internal register only on the same frame-boundary cycle, so there is no tearing mid-frame.
REQ-020 frame_o SHALL be high for exactly one pix_en cycle per frame, aligned with row=0, col=0.

Reset
REQ-021 While rstn is low, the block SHALL hold:
- hcnt = vcnt = row = col = 0;
- vs_no = hs_no = 1, blank_no = 0;
- RGB = 0, color_o = 0, frame_o = 0, en_o = 0;
- sq_x = (H_ACTIVE-SQ_SIZE)/2 = 304, sq_y = 224, dx = dy = +1, pattern register = 0.
REQ-022 Reset asserted mid-frame SHALL restart timing from row 0, col 0 on the first pix_en after release.

Structure
REQ-023 Timing defaults, H_TOTAL/V_TOTAL and the colour-bar constant table SHALL reside in shared package video_pkg.
REQ-024 The horizontal/vertical counter pair SHALL be a single sub-module, video_counter. Pattern and square logic stay in the top level.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- pix_en held at 1 for 2 frames -> hs_no low for 96 cycles per line starting at col 656; vs_no low for 1600 cycles; frame_o pulses 420000 cycles apart.
- pattern_sel=1 at row 10 -> col 0..79 RGB FF/FF/FF; col 80 FF/FF/00; col 560..639 00/00/00; col 640 00/00/00 with blank_no=0.
- pattern_sel=2 after reset -> color_o high at (row 224, col 304) and (255, 335); low at (224, 336). The next frame is offset by +1,+1.
- Square forced by repeated frames to sq_x=608 with dx=+1 -> the next frame has sq_x=607 and dx=-1.
- pix_en toggling 1/0 -> outputs change only on pix_en cycles; en_o follows pix_en one cycle late.
- rstn pulsed low at row 300 -> all outputs take their reset values immediately; after release, row/col restart at 0,0.
